// File: rtl/register_bank_pkg.sv
// Shared pipeline constants and the register-bank dump state encoding.
package register_bank_pkg;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int N_REGS  = 2 ** NB_REG;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/register_bank.sv
// Decode-stage register file: two bypassed read ports, one writeback port,
// and a valid/ready debug dump that streams every register in order.
module register_bank #(
    parameter int NB_DATA = register_bank_pkg::NB_DATA,
    parameter int NB_REG  = register_bank_pkg::NB_REG,
    parameter int N_REGS  = 2 ** NB_REG
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_reg_write,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic [NB_DATA-1:0] i_write_data,
    input  logic [NB_REG-1:0]  i_read_reg_a,
    input  logic [NB_REG-1:0]  i_read_reg_b,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic [NB_REG-1:0]  o_dump_index,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_done,
    output logic               o_busy
);

    import register_bank_pkg::*;

    localparam logic [NB_REG-1:0] LAST_IDX = NB_REG'(N_REGS - 1);

    logic [NB_DATA-1:0] regs [N_REGS];
    logic               wr_en;
    dump_state_t        state_q;
    dump_state_t        state_d;
    logic [NB_REG-1:0]  idx_q;
    logic [NB_REG-1:0]  idx_d;

    assign wr_en = i_reg_write && (i_write_reg != '0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[i_write_reg] <= i_write_data;
        end
    end

    // Writeback data is forwarded so a same-cycle reader sees the new value.
    always_comb begin
        o_data_a = '0;
        o_data_b = '0;
        if (wr_en && (i_write_reg == i_read_reg_a)) begin
            o_data_a = i_write_data;
        end else if (i_read_reg_a != '0) begin
            o_data_a = regs[i_read_reg_a];
        end
        if (wr_en && (i_write_reg == i_read_reg_b)) begin
            o_data_b = i_write_data;
        end else if (i_read_reg_b != '0) begin
            o_data_b = regs[i_read_reg_b];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Dump words come from stored state only, so an accepted word
    // carries the value held before any same-cycle write.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        o_dump_valid = 1'b0;
        o_dump_done  = 1'b0;
        o_dump_data  = '0;
        unique case (state_q)
            DUMP_IDLE: begin
                idx_d = '0;
                if (i_dump_start) begin
                    state_d = DUMP_SEND;
                end
            end
            DUMP_SEND: begin
                o_dump_valid = 1'b1;
                if (idx_q != '0) begin
                    o_dump_data = regs[idx_q];
                end
                if (i_dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DUMP_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DUMP_DONE: begin
                o_dump_done = 1'b1;
                state_d     = DUMP_IDLE;
                idx_d       = '0;
            end
            default: begin
                state_d = DUMP_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign o_dump_index = (state_q == DUMP_IDLE) ? '0 : idx_q;
    assign o_busy       = (state_q != DUMP_IDLE);

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: writes, bypass, r0, dump flow, reset.
module tb_register_bank;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_reg_write = 1'b0;
    logic [4:0]  i_write_reg = '0;
    logic [31:0] i_write_data = '0;
    logic [4:0]  i_read_reg_a = '0;
    logic [4:0]  i_read_reg_b = '0;
    logic [31:0] o_data_a;
    logic [31:0] o_data_b;
    logic        i_dump_start = 1'b0;
    logic        i_dump_ready = 1'b0;
    logic        o_dump_valid;
    logic [4:0]  o_dump_index;
    logic [31:0] o_dump_data;
    logic        o_dump_done;
    logic        o_busy;

    int n_checks = 0;
    int n_fails  = 0;

    register_bank dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_reg_write  (i_reg_write),
        .i_write_reg  (i_write_reg),
        .i_write_data (i_write_data),
        .i_read_reg_a (i_read_reg_a),
        .i_read_reg_b (i_read_reg_b),
        .o_data_a     (o_data_a),
        .o_data_b     (o_data_b),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_index (o_dump_index),
        .o_dump_data  (o_dump_data),
        .o_dump_done  (o_dump_done),
        .o_busy       (o_busy)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        i_reg_write  = 1'b1;
        i_write_reg  = r;
        i_write_data = d;
        tick();
        i_reg_write  = 1'b0;
    endtask

    task automatic start_dump();
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
    endtask

    initial begin
        bit seen;
        tick();
        tick();
        i_reset = 1'b0;
        #1;
        check("rst_valid", 32'(o_dump_valid), 0);
        check("rst_busy",  32'(o_busy), 0);
        check("rst_done",  32'(o_dump_done), 0);
        check("rst_index", 32'(o_dump_index), 0);
        check("rst_ddata", o_dump_data, 0);
        i_read_reg_a = 5;
        #1;
        check("rst_r5", o_data_a, 0);

        // write then read
        wr(5, 32'hDEADBEEF);
        i_read_reg_a = 5;
        i_read_reg_b = 0;
        #1;
        check("r5_a", o_data_a, 32'hDEADBEEF);
        check("r0_b", o_data_b, 0);

        // r0 is hardwired
        wr(0, 32'h12345678);
        i_read_reg_a = 0;
        i_read_reg_b = 0;
        #1;
        check("r0_a", o_data_a, 0);
        check("r0_b2", o_data_b, 0);

        // same-cycle bypass
        i_reg_write  = 1'b1;
        i_write_reg  = 7;
        i_write_data = 32'hA5A5A5A5;
        i_read_reg_a = 7;
        i_read_reg_b = 7;
        #1;
        check("byp_a", o_data_a, 32'hA5A5A5A5);
        check("byp_b", o_data_b, 32'hA5A5A5A5);
        tick();
        i_reg_write = 1'b0;
        #1;
        check("r7_after", o_data_a, 32'hA5A5A5A5);
        check("r7_after_b", o_data_b, 32'hA5A5A5A5);

        // full dump with ready held high
        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i * 4));
        i_dump_ready = 1'b1;
        start_dump();
        for (int k = 0; k < 32; k++) begin
            check($sformatf("dv%0d", k), 32'(o_dump_valid), 1);
            check($sformatf("di%0d", k), 32'(o_dump_index), 32'(k));
            check($sformatf("dd%0d", k), o_dump_data, 32'(k * 4));
            check($sformatf("dn%0d", k), 32'(o_dump_done), 0);
            tick();
        end
        check("done_pulse", 32'(o_dump_done), 1);
        check("done_valid", 32'(o_dump_valid), 0);
        tick();
        check("done_clear", 32'(o_dump_done), 0);
        check("idle_busy", 32'(o_busy), 0);
        check("idle_index", 32'(o_dump_index), 0);

        // start ignored while dumping is covered below; ready toggling
        i_dump_ready = 1'b1;
        start_dump();
        check("tg_i0", 32'(o_dump_index), 0);
        tick();
        i_dump_ready = 1'b0;
        #1;
        check("tg_i1a", 32'(o_dump_index), 1);
        wr(1, 32'h55);
        check("tg_i1b", 32'(o_dump_index), 1);
        check("tg_track", o_dump_data, 32'h55);
        check("tg_valid", 32'(o_dump_valid), 1);
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        check("tg_i1c", 32'(o_dump_index), 1);
        i_dump_ready = 1'b1;
        tick();
        check("tg_i2", 32'(o_dump_index), 2);
        tick();
        check("tg_i3", 32'(o_dump_index), 3);
        check("old_r3", o_dump_data, 32'd12);
        wr(3, 32'hFF);
        check("tg_i4", 32'(o_dump_index), 4);
        i_read_reg_a = 3;
        #1;
        check("new_r3", o_data_a, 32'hFF);
        seen = 0;
        for (int c = 0; c < 64 && !seen; c++) begin
            if (o_dump_done) seen = 1;
            else tick();
        end
        check("tg_done_seen", 32'(seen), 1);
        tick();
        check("tg_idle", 32'(o_busy), 0);

        // reset mid-dump
        start_dump();
        for (int c = 0; c < 10; c++) tick();
        check("ab_idx10", 32'(o_dump_index), 10);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        check("ab_valid", 32'(o_dump_valid), 0);
        check("ab_busy",  32'(o_busy), 0);
        check("ab_done",  32'(o_dump_done), 0);
        check("ab_index", 32'(o_dump_index), 0);
        for (int i = 0; i < 32; i++) begin
            i_read_reg_a = 5'(i);
            i_read_reg_b = 5'(31 - i);
            #1;
            check($sformatf("ab_ra%0d", i), o_data_a, 0);
            check($sformatf("ab_rb%0d", i), o_data_b, 0);
        end
        tick();
        check("ab_done2", 32'(o_dump_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
